alu_mem_sequencer: RTL and testbench

//  Command sequencer for the 2-bit ALU and its 4-entry result memory.

---
 rtl/alu_mem_sequencer.sv | 157 +++++++++++++++
 tb/tb_alu_mem_sequencer.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_mem_sequencer.sv
// Command sequencer for a 2-bit ALU with a 4-entry result memory: queues commands, drives the
// ALU one command at a time, pulses the write enable and returns the captured result.
module alu_mem_sequencer #(
    parameter int unsigned FIFO_DEPTH    = 4,
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned ERR_CNT_W     = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [1:0]           cmd_a,
    input  logic [1:0]           cmd_b,
    input  logic [1:0]           cmd_addr,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [3:0]           rsp_y,
    output logic                 rsp_c,
    output logic [1:0]           rsp_addr,
    output logic [1:0]           alu_a,
    output logic [1:0]           alu_b,
    output logic [1:0]           alu_ctrl,
    output logic [1:0]           alu_addr,
    output logic                 alu_we,
    input  logic [3:0]           alu_y,
    input  logic                 alu_c,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_cnt
);

    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW = PtrW + 1;
    localparam int unsigned SetW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    typedef enum logic [2:0] {StIdle, StDrive, StSettle, StWrite, StResp} state_e;

    // Command word layout: {op[7:6], a[5:4], b[3:2], addr[1:0]}
    logic [7:0]          fifo_q [FIFO_DEPTH];
    logic [PtrW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CntW-1:0]     count_q;
    logic                push, pop, fifo_empty;

    state_e              state_q;
    logic [7:0]          cmd_q;
    logic [SetW-1:0]     settle_q;
    logic [1:0]          alu_a_q, alu_b_q, alu_ctrl_q, alu_addr_q;
    logic                alu_we_q;
    logic                rsp_valid_q, rsp_c_q;
    logic [3:0]          rsp_y_q;
    logic [1:0]          rsp_addr_q;
    logic [ERR_CNT_W-1:0] err_q;
    logic                div_zero;

    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = ~rst & (count_q != CntW'(FIFO_DEPTH));
    assign push       = cmd_valid & cmd_ready;
    assign pop        = (state_q == StIdle) & ~fifo_empty;
    assign div_zero   = (cmd_q[7:6] == 2'b11) & (cmd_q[3:2] == 2'b00);

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= {cmd_op, cmd_a, cmd_b, cmd_addr};
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (pop && !push) count_q <= count_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cmd_q       <= '0;
            settle_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_ctrl_q  <= '0;
            alu_addr_q  <= '0;
            alu_we_q    <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= '0;
            rsp_c_q     <= 1'b0;
            rsp_addr_q  <= '0;
            err_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (!fifo_empty) begin
                        cmd_q   <= fifo_q[rd_ptr_q];
                        state_q <= StDrive;
                    end
                end
                StDrive: begin
                    alu_ctrl_q <= cmd_q[7:6];
                    alu_a_q    <= cmd_q[5:4];
                    alu_b_q    <= cmd_q[3:2];
                    alu_addr_q <= cmd_q[1:0];
                    settle_q   <= SetW'(SETTLE_CYCLES - 1);
                    state_q    <= StSettle;
                end
                StSettle: begin
                    if (settle_q == '0) begin
                        alu_we_q <= ~div_zero;
                        state_q  <= StWrite;
                    end else begin
                        settle_q <= settle_q - 1'b1;
                    end
                end
                StWrite: begin
                    alu_we_q    <= 1'b0;
                    rsp_valid_q <= 1'b1;
                    rsp_addr_q  <= cmd_q[1:0];
                    if (div_zero) begin
                        rsp_y_q <= '0;
                        rsp_c_q <= 1'b1;
                        if (err_q != '1) err_q <= err_q + 1'b1;
                    end else begin
                        rsp_y_q <= alu_y;
                        rsp_c_q <= alu_c;
                    end
                    state_q <= StResp;
                end
                StResp: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_ctrl  = alu_ctrl_q;
    assign alu_addr  = alu_addr_q;
    assign alu_we    = alu_we_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign rsp_c     = rsp_c_q;
    assign rsp_addr  = rsp_addr_q;
    assign err_cnt   = err_q;
    assign busy      = (state_q != StIdle) | ~fifo_empty;

endmodule

// File: tb/tb_alu_mem_sequencer.sv
// Directed-plus-random bench for alu_mem_sequencer with an ALU/memory stand-in and a
// queue-based reference model of command order, results, writes and error count.
module tb_alu_mem_sequencer;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst, cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_c, alu_we, alu_c, busy;
    logic [1:0] cmd_op, cmd_a, cmd_b, cmd_addr, rsp_addr, alu_a, alu_b, alu_ctrl, alu_addr;
    logic [3:0] rsp_y, alu_y;
    logic [7:0] err_cnt;

    always #5 clk = ~clk;

    alu_mem_sequencer #(.FIFO_DEPTH(DEPTH), .SETTLE_CYCLES(1), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_addr(cmd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_c(rsp_c),
        .rsp_addr(rsp_addr), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_addr(alu_addr), .alu_we(alu_we), .alu_y(alu_y), .alu_c(alu_c),
        .busy(busy), .err_cnt(err_cnt)
    );

    // ALU behaviour: returns {c, y}. Divide by zero yields junk the sequencer must discard.
    function automatic logic [4:0] alu_fn(input logic [1:0] op, input logic [1:0] a,
                                          input logic [1:0] b);
        int ia, ib, r;
        ia = int'(a);
        ib = int'(b);
        case (op)
            2'd0: begin r = ia + ib; return {r > 3, 4'(r)}; end
            2'd1: begin r = ia - ib; return {r < 0, 4'(r)}; end
            2'd2: begin r = ia * ib; return {1'b0, 4'(r)}; end
            default: begin
                if (ib == 0) return {1'b0, 4'hF};
                r = ia / ib;
                return {1'b0, 4'(r)};
            end
        endcase
    endfunction

    always_comb {alu_c, alu_y} = alu_fn(alu_ctrl, alu_a, alu_b);

    logic [3:0] mem_tb [4];
    always @(posedge clk) if (alu_we) mem_tb[alu_addr] <= alu_y;

    typedef struct packed {logic [1:0] op; logic [1:0] a; logic [1:0] b; logic [1:0] addr;} cmd_t;
    cmd_t       cq[$];
    int         checks = 0, failures = 0;
    int         n_acc = 0, n_rsp = 0, n_wr = 0, n_wr_exp = 0, err_exp = 0;
    logic [3:0] mem_exp [4];
    logic [3:0] mem_vld = '0;
    logic       acc = 1'b0, we_prev = 1'b0, last_c;
    logic [3:0] last_y;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: observe handshakes before the edge, update the model, settle after the edge.
    task automatic tick();
        cmd_t f;
        logic [4:0] r;
        @(negedge clk);
        acc = cmd_valid && cmd_ready;
        if (alu_we) begin
            n_wr++;
            check("we_single_pulse", {31'd0, we_prev}, 0);
            check("we_inflight", {31'd0, cq.size() != 0}, 1);
            if (cq.size() != 0) begin
                f = cq[0];
                check("we_operands", {24'd0, alu_ctrl, alu_a, alu_b, alu_addr}, {24'd0, f});
            end
        end
        we_prev = alu_we;
        if (rsp_valid && rsp_ready) begin
            check("rsp_expected", {31'd0, cq.size() != 0}, 1);
            if (cq.size() != 0) begin
                f = cq.pop_front();
                if (f.op == 2'd3 && f.b == 2'd0) begin
                    r = 5'b10000;
                    err_exp = (err_exp == 255) ? 255 : err_exp + 1;
                end else begin
                    r = alu_fn(f.op, f.a, f.b);
                    n_wr_exp++;
                    mem_exp[f.addr] = r[3:0];
                    mem_vld[f.addr] = 1'b1;
                end
                check("rsp_data", {25'd0, rsp_c, rsp_y, rsp_addr}, {25'd0, r, f.addr});
                last_y = rsp_y;
                last_c = rsp_c;
                n_rsp++;
            end
        end
        if (acc) begin
            cq.push_back({cmd_op, cmd_a, cmd_b, cmd_addr});
            n_acc++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [1:0] a, input logic [1:0] b,
                        input logic [1:0] addr);
        cmd_valid = 1'b1;
        cmd_op = op; cmd_a = a; cmd_b = b; cmd_addr = addr;
        for (int i = 0; i < 200; i++) begin
            tick();
            if (acc) break;
        end
        check("send_accepted", {31'd0, acc}, 1);
        cmd_valid = 1'b0;
    endtask

    task automatic send_rand();
        send(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
             2'($urandom_range(0, 3)));
    endtask

    task automatic drain();
        rsp_ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (cq.size() == 0 && !busy) break;
            tick();
        end
        check("drain_done", {31'd0, cq.size() == 0 && !busy}, 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        tick();
        tick();
        check("rst_cmd_ready", {31'd0, cmd_ready}, 0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_err_cnt", {24'd0, err_cnt}, 0);
        check("rst_alu_we", {31'd0, alu_we}, 0);
        cq.delete();
        err_exp = 0;
        we_prev = 1'b0;
        rst = 1'b0;
        #1;
        check("post_rst_cmd_ready", {31'd0, cmd_ready}, 1);
    endtask

    initial begin
        int base_rsp, base_wr, cnt;
        cmd_valid = 1'b0; rsp_ready = 1'b0; rst = 1'b1;
        cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_addr = '0;
        #1;
        do_reset();

        // Add with latency measurement: response must appear after edge k+4.
        cmd_valid = 1'b1; cmd_op = 2'd0; cmd_a = 2'd2; cmd_b = 2'd1; cmd_addr = 2'd0;
        tick();
        check("lat_accept", {31'd0, acc}, 1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lat_early_rsp", {31'd0, rsp_valid}, 0);
        end
        tick();
        check("lat_rsp_valid", {31'd0, rsp_valid}, 1);
        check("add_rsp", {25'd0, rsp_c, rsp_y, rsp_addr}, {25'd0, 1'b0, 4'd3, 2'd0});
        check("add_one_write", n_wr, 1);
        drain();

        // Subtract with borrow.
        send(2'd1, 2'd1, 2'd2, 2'd3);
        drain();
        check("sub_y", {28'd0, last_y}, 32'hF);
        check("sub_c", {31'd0, last_c}, 1);
        check("sub_err_cnt", {24'd0, err_cnt}, 0);

        // Divide by zero, then saturation of the error counter.
        base_wr = n_wr;
        send(2'd3, 2'd2, 2'd0, 2'd3);
        drain();
        check("div0_y", {28'd0, last_y}, 0);
        check("div0_c", {31'd0, last_c}, 1);
        check("div0_err_cnt", {24'd0, err_cnt}, 1);
        check("div0_no_write", n_wr, base_wr);
        for (int i = 0; i < 259; i++) send(2'd3, 2'($urandom_range(0, 3)), 2'd0,
                                           2'($urandom_range(0, 3)));
        drain();
        check("err_saturated", {24'd0, err_cnt}, 255);
        check("err_model", {24'd0, err_cnt}, err_exp);

        // Burst of 6 with the response port stalled: one in flight plus a full FIFO.
        base_rsp = n_rsp;
        rsp_ready = 1'b0;
        cnt = 0;
        cmd_valid = 1'b1;
        {cmd_op, cmd_a, cmd_b, cmd_addr} = 8'($urandom);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (acc) begin
                cnt++;
                {cmd_op, cmd_a, cmd_b, cmd_addr} = 8'($urandom);
            end
        end
        check("burst_accepted", cnt, DEPTH + 1);
        check("burst_full_ready", {31'd0, cmd_ready}, 0);
        check("burst_busy", {31'd0, busy}, 1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 100 && cnt < 6; i++) begin
            tick();
            if (acc) cnt++;
        end
        cmd_valid = 1'b0;
        drain();
        check("burst_rsp_count", n_rsp - base_rsp, 6);

        // Reset while the first command sits in SETTLE with two more queued.
        rsp_ready = 1'b0;
        send_rand();
        send_rand();
        send_rand();
        base_wr = n_wr;
        base_rsp = n_rsp;
        do_reset();
        for (int i = 0; i < 6; i++) tick();
        check("abort_no_write", n_wr, base_wr);
        check("abort_no_rsp", {31'd0, rsp_valid}, 0);
        check("abort_busy", {31'd0, busy}, 0);
        check("abort_ready", {31'd0, cmd_ready}, 1);

        // Simultaneous push/pop at DEPTH-1 and pointer wrap over many commands.
        base_rsp = n_rsp;
        rsp_ready = 1'b0;
        for (int i = 0; i < DEPTH; i++) send_rand();
        for (int i = 0; i < 20 && !rsp_valid; i++) tick();
        check("wrap_stalled_rsp", {31'd0, rsp_valid}, 1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 3 * DEPTH + 2; i++) send_rand();
        drain();
        check("wrap_rsp_count", n_rsp - base_rsp, 3 * DEPTH + 2 + DEPTH);
        check("total_writes", n_wr, n_wr_exp);
        check("final_err_cnt", {24'd0, err_cnt}, err_exp);
        check("all_accepted_answered", n_acc - n_rsp, 3);
        for (int i = 0; i < 4; i++) begin
            if (mem_vld[i]) check("mem_contents", {28'd0, mem_tb[i]}, {28'd0, mem_exp[i]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
